stream_arb_2x1: RTL and testbench

STREAM_ARB_2X1 -- requirements
Module: stream_arb_2x1

---
 rtl/stream_arb_2x1.sv | 82 ++++++++
 tb/tb_stream_arb_2x1.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_2x1.sv
// Two-source round-robin stream arbiter with a registered output stage.
// Each source also has a saturating count of the beats accepted from it.
module stream_arb_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_sel,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
);

    logic [WIDTH-1:0] r_y_data;
    logic             r_y_valid;
    logic             r_y_sel;
    logic             r_prio;

    logic             w_load_en;
    logic             w_grant_a;
    logic             w_grant_b;
    logic [1:0]       w_xfer;

    // prio = 0 favours A on a tie, prio = 1 favours B.
    assign w_load_en = !r_y_valid || y_ready;
    assign w_grant_a = a_valid && (!b_valid || !r_prio);
    assign w_grant_b = b_valid && (!a_valid ||  r_prio);

    // Readies are forced low during reset so nothing is accepted while it is held.
    assign a_ready   = w_load_en && w_grant_a && !rst;
    assign b_ready   = w_load_en && w_grant_b && !rst;
    assign w_xfer[0] = a_valid && a_ready;
    assign w_xfer[1] = b_valid && b_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
            r_y_sel   <= 1'b0;
            r_prio    <= 1'b0;
        end else if (w_load_en) begin
            r_y_valid <= |w_xfer;
            if (w_xfer[0]) begin
                r_y_data <= a_data;
                r_y_sel  <= 1'b0;
                r_prio   <= 1'b1;
            end else if (w_xfer[1]) begin
                r_y_data <= b_data;
                r_y_sel  <= 1'b1;
                r_prio   <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [7:0] r_count;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= 8'd0;
                end else if (w_xfer[gi] && (r_count != 8'hFF)) begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    endgenerate

    assign a_count = g_cnt[0].r_count;
    assign b_count = g_cnt[1].r_count;
    assign y_data  = r_y_data;
    assign y_valid = r_y_valid;
    assign y_sel   = r_y_sel;

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Directed bench for stream_arb_2x1: a vector table of single-cycle steps,
// plus hand-written sequences for asynchronous reset and counter saturation.
module tb_stream_arb_2x1;

    logic       clk;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] y_data;
    logic       y_valid;
    logic       y_ready;
    logic       y_sel;
    logic [7:0] a_count;
    logic [7:0] b_count;

    int checks;
    int failures;

    stream_arb_2x1 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_sel   (y_sel),
        .a_count (a_count),
        .b_count (b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_before;
        logic [7:0] a_d;
        logic       a_v;
        logic [7:0] b_d;
        logic       b_v;
        logic       y_r;
        logic       exp_ar;
        logic       exp_br;
        logic       exp_yv;
        logic [7:0] exp_yd;
        logic       exp_ys;
        logic [7:0] exp_ac;
        logic [7:0] exp_bc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rb, logic [7:0] ad, logic av, logic [7:0] bd, logic bv,
                                logic yr, logic ar, logic br, logic yv, logic [7:0] yd,
                                logic ys, logic [7:0] ac, logic [7:0] bc);
        vec_t v;
        v.rst_before = rb; v.a_d = ad; v.a_v = av; v.b_d = bd; v.b_v = bv; v.y_r = yr;
        v.exp_ar = ar; v.exp_br = br; v.exp_yv = yv; v.exp_yd = yd; v.exp_ys = ys;
        v.exp_ac = ac; v.exp_bc = bc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic yv, input logic [7:0] yd,
                               input logic ys, input logic [7:0] ac, input logic [7:0] bc);
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(yv));
        chk({tag, ".y_data"},  32'(y_data),  32'(yd));
        chk({tag, ".y_sel"},   32'(y_sel),   32'(ys));
        chk({tag, ".a_count"}, 32'(a_count), 32'(ac));
        chk({tag, ".b_count"}, 32'(b_count), 32'(bc));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a_data   = 8'h00;
        a_valid  = 1'b0;
        b_data   = 8'h00;
        b_valid  = 1'b0;
        y_ready  = 1'b0;

        // rb  a_d   av b_d   bv yr | ar br yv y_d   ys ac  bc
        // Alternation, then drain.
        vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 1,  1, 0, 1, 8'h11, 0, 8'd1, 8'd0));
        vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 1,  0, 1, 1, 8'h22, 1, 8'd1, 8'd1));
        vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 1,  1, 0, 1, 8'h11, 0, 8'd2, 8'd1));
        vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 1,  0, 1, 1, 8'h22, 1, 8'd2, 8'd2));
        vq.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h22, 1, 8'd2, 8'd2));
        // Single source B after a reset, then drain.
        vq.push_back(mk(1, 8'h00, 0, 8'h33, 1, 1,  0, 1, 1, 8'h33, 1, 8'd0, 8'd1));
        vq.push_back(mk(0, 8'h00, 0, 8'h33, 1, 1,  0, 1, 1, 8'h33, 1, 8'd0, 8'd2));
        vq.push_back(mk(0, 8'h00, 0, 8'h33, 1, 1,  0, 1, 1, 8'h33, 1, 8'd0, 8'd3));
        vq.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h33, 1, 8'd0, 8'd3));
        // Back-pressure: load A, stall 5 cycles, then B is next.
        vq.push_back(mk(1, 8'h11, 1, 8'h22, 1, 1,  1, 0, 1, 8'h11, 0, 8'd1, 8'd0));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 0,  0, 0, 1, 8'h11, 0, 8'd1, 8'd0));
        vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 1,  0, 1, 1, 8'h22, 1, 8'd1, 8'd1));
        vq.push_back(mk(0, 8'h11, 1, 8'h22, 1, 1,  1, 0, 1, 8'h11, 0, 8'd2, 8'd1));
        // Lone A under stall, then accepted; tie afterwards goes to B.
        vq.push_back(mk(0, 8'h44, 1, 8'h00, 0, 0,  0, 0, 1, 8'h11, 0, 8'd2, 8'd1));
        vq.push_back(mk(0, 8'h44, 1, 8'h00, 0, 1,  1, 0, 1, 8'h44, 0, 8'd3, 8'd1));
        vq.push_back(mk(0, 8'h55, 1, 8'h66, 1, 1,  0, 1, 1, 8'h66, 1, 8'd3, 8'd2));
        // Reset mid-operation: first tie after release goes to A.
        vq.push_back(mk(1, 8'h77, 1, 8'h88, 1, 1,  1, 0, 1, 8'h77, 0, 8'd1, 8'd0));
        vq.push_back(mk(0, 8'h5A, 1, 8'h00, 0, 1,  1, 0, 1, 8'h5A, 0, 8'd2, 8'd0));

        #2;
        chk("reset.a_ready", 32'(a_ready), 32'd0);
        chk("reset.b_ready", 32'(b_ready), 32'd0);
        chk_outputs("reset", 1'b0, 8'h00, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            @(negedge clk);
            if (vq[k].rst_before) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            a_data  = vq[k].a_d;
            a_valid = vq[k].a_v;
            b_data  = vq[k].b_d;
            b_valid = vq[k].b_v;
            y_ready = vq[k].y_r;
            #1;
            chk($sformatf("vec%0d.a_ready", k), 32'(a_ready), 32'(vq[k].exp_ar));
            chk($sformatf("vec%0d.b_ready", k), 32'(b_ready), 32'(vq[k].exp_br));
            @(posedge clk);
            #1;
            chk_outputs($sformatf("vec%0d", k), vq[k].exp_yv, vq[k].exp_yd, vq[k].exp_ys,
                        vq[k].exp_ac, vq[k].exp_bc);
            $display("vec%0d a=%0h/%0b b=%0h/%0b yr=%0b -> y=%0h v=%0b sel=%0b ac=%0d bc=%0d",
                     k, a_data, a_valid, b_data, b_valid, y_ready, y_data, y_valid, y_sel,
                     a_count, b_count);
        end

        // Asynchronous reset between edges while a 0x5A beat is held.
        @(negedge clk);
        y_ready = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #2;
        chk("areset.pre_y_valid", 32'(y_valid), 32'd1);
        chk("areset.pre_y_data",  32'(y_data),  32'h5A);
        rst = 1'b1;
        #1;
        chk("areset.a_ready", 32'(a_ready), 32'd0);
        chk("areset.b_ready", 32'(b_ready), 32'd0);
        chk_outputs("areset", 1'b0, 8'h00, 1'b0, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        chk_outputs("areset_held", 1'b0, 8'h00, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: 300 back-to-back beats from A only.
        a_valid = 1'b1;
        b_valid = 1'b0;
        y_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a_data = 8'(i);
            @(posedge clk);
            #1;
            if (i == 253) chk("sat.a_count_254", 32'(a_count), 32'd254);
            if (i == 254) chk("sat.a_count_255", 32'(a_count), 32'd255);
            if (i == 255) chk("sat.a_count_nowrap", 32'(a_count), 32'd255);
            @(negedge clk);
        end
        $display("saturation 300 beats from A -> a_count=%0d b_count=%0d", a_count, b_count);
        chk_outputs("sat_end", 1'b1, 8'(299), 1'b0, 8'd255, 8'd0);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("sat_drain", 1'b0, 8'(299), 1'b0, 8'd255, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
